// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
//   sched_state_e : scheduler FSM states
//   CFG_*         : frame-format register width, reset value and field indices
package uart_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, HOLD} sched_state_e;

  localparam int CFG_W = 5;
  // 8 data bits, no parity, 1 stop bit
  localparam logic [CFG_W-1:0] CFG_DEFAULT = 5'b00011;

  localparam int CFG_LEN_LSB = 0;  // [1:0] data length code, 5..8 bits
  localparam int CFG_LEN_MSB = 1;
  localparam int CFG_STOP2   = 2;  // two stop bits
  localparam int CFG_PAR_EN  = 3;  // parity enable
  localparam int CFG_PAR_ODD = 4;  // odd parity when enabled

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        : request vector
//   ptr        : highest-priority index this cycle
//   gnt_onehot : one-hot grant (first request at/after ptr, circular)
//   gnt_id     : binary index of the grant
//   any        : at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt_onehot,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       any
);
  localparam int IW = $clog2(NUM_REQ);

  int idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_id     = '0;
    any        = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[IW'(idx)]) begin
        any                    = 1'b1;
        gnt_id                 = IW'(idx);
        gnt_onehot[IW'(idx)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx serializer between NUM_REQ byte-stream requesters.
// Round-robin grant with per-packet lock, one byte in flight at a time,
// frame-format updates only at packet boundaries, and a watchdog that
// drops a grant whose serializer or requester stalls.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   req_valid/data/last    : per-requester byte stream (byte i at [i*DATA_W +: DATA_W])
//   req_ready              : one-hot accept strobe
//   cfg_wr, cfg_wdata      : frame-format update request
//   cfg_reg                : frame format driven to uart_tx
//   tx_start, tx_data      : launch pulse and byte to uart_tx
//   tx_done                : frame-complete pulse from uart_tx
//   grant_id               : current/last granted requester
//   busy                   : transfer in progress or format update pending
//   err_timeout            : one-cycle watchdog expiry pulse
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        cfg_wr,
  input  logic [CFG_W-1:0]            cfg_wdata,
  output logic [CFG_W-1:0]            cfg_reg,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_done,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        err_timeout
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  // timer is 0 on the first cycle of a waiting state, so this value marks
  // the TIMEOUT_CYC-th cycle spent waiting
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  sched_state_e       state, state_nxt;
  logic [IW-1:0]      rr_ptr, gid, gid_inc, acc_id, arb_id;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_any, accept, last_r, expire;
  logic [TW-1:0]      timer;
  logic [CFG_W-1:0]   cfg_shadow;
  logic               cfg_pend;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (arb_gnt),
    .gnt_id     (arb_id),
    .any        (arb_any)
  );

  assign gid_inc  = (gid == IW'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
  assign expire   = (timer == T_LAST);
  assign grant_id = gid;
  assign busy     = (state != IDLE) || cfg_pend;

  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    tx_start    = 1'b0;
    err_timeout = 1'b0;
    accept      = 1'b0;
    acc_id      = gid;
    case (state)
      IDLE: begin
        // a pending format update owns this cycle; arbitration waits one cycle
        if (!cfg_pend && arb_any) begin
          req_ready = arb_gnt;
          accept    = 1'b1;
          acc_id    = arb_id;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start  = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done)     state_nxt = last_r ? IDLE : HOLD;
        else if (expire) begin
          err_timeout = 1'b1;
          state_nxt   = IDLE;
        end
      end
      HOLD: begin
        // packet lock: only the owning requester may continue
        if (req_valid[gid]) begin
          req_ready[gid] = 1'b1;
          accept         = 1'b1;
          state_nxt      = LAUNCH;
        end else if (expire) begin
          err_timeout = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gid        <= '0;
      last_r     <= 1'b0;
      tx_data    <= '0;
      timer      <= '0;
      cfg_reg    <= CFG_DEFAULT;
      cfg_shadow <= CFG_DEFAULT;
      cfg_pend   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state)                     timer <= '0;
      else if (state == WAIT_DONE || state == HOLD) timer <= timer + 1'b1;

      if (accept) begin
        gid     <= acc_id;
        tx_data <= req_data[int'(acc_id)*DATA_W +: DATA_W];
        last_r  <= req_last[acc_id];
      end

      // pointer advances past the owner at packet end or on a dropped lock
      if ((state == WAIT_DONE && tx_done && last_r) || err_timeout)
        rr_ptr <= gid_inc;

      if (cfg_wr) cfg_shadow <= cfg_wdata;
      if (state == IDLE && cfg_pend) cfg_reg <= cfg_shadow;
      // a write landing on the apply cycle stays pending for the next IDLE cycle
      cfg_pend <= cfg_wr || (cfg_pend && state != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_last  = '0;
  logic [3:0]  req_ready;
  logic        cfg_wr;
  logic [4:0]  cfg_wdata;
  logic [4:0]  cfg_reg;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err_timeout;

  int vecs = 0;
  int errs = 0;

  uart_tx_sched #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .cfg_wr(cfg_wr), .cfg_wdata(cfg_wdata), .cfg_reg(cfg_reg),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Requester sources: per-channel byte FIFOs {last, data}, popped on valid&ready.
  logic [8:0] mem [4][16];
  int         wp [4];
  int         rp [4];
  logic [3:0] acc = '0;

  always @(negedge clk) acc = req_valid & req_ready;

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) rp[i]++;
      if (rp[i] < wp[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = mem[i][rp[i]][7:0];
        req_last[i]        = mem[i][rp[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  end

  task automatic push(input int ch, input logic lst, input logic [7:0] d);
    mem[ch][wp[ch]] = {lst, d};
    wp[ch]++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded search for tx_start at negedges; n = cycles until it was seen.
  task automatic wait_start(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_start && n < 50);
    chk("start_seen", 32'(tx_start), 32'd1);
  endtask

  // One byte: check launch, answer with tx_done after dly cycles, then check
  // req_ready on the first cycle after completion.
  task automatic frame(input int id, input logic [7:0] d, input int dly,
                       input logic [3:0] rdy_after, input int exp_n);
    int n;
    wait_start(n);
    if (exp_n > 0) chk("start_latency", n, exp_n);
    chk("grant_id", 32'(grant_id), id);
    chk("tx_data", 32'(tx_data), 32'(d));
    repeat (dly) begin @(posedge clk); #1; end
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    @(negedge clk);
    chk("ready_after_done", 32'(req_ready), 32'(rdy_after));
  endtask

  initial begin
    int n;
    rst = 1'b1; cfg_wr = 1'b0; cfg_wdata = '0; tx_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_reg", 32'(cfg_reg), 32'h03);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // three single-byte packets at once, ptr 0 -> order 0,1,2
    push(0, 1'b1, 8'h11); push(1, 1'b1, 8'h22); push(2, 1'b1, 8'h33);
    @(negedge clk);
    chk("rr_first_ready", 32'(req_ready), 32'h1);
    frame(0, 8'h11, 2, 4'b0010, 1);
    frame(1, 8'h22, 1, 4'b0100, 1);
    frame(2, 8'h33, 1, 4'b0000, 1);
    // ptr now 3: req3 wins over req0, then wrap to req0
    push(0, 1'b1, 8'h44); push(3, 1'b1, 8'h77);
    frame(3, 8'h77, 1, 4'b0001, 2);
    frame(0, 8'h44, 1, 4'b0000, 1);

    // locked 3-byte packet on req1 while req2 waits
    push(1, 1'b0, 8'hA5); push(1, 1'b0, 8'h5A); push(1, 1'b1, 8'hFF);
    push(2, 1'b1, 8'hB2);
    frame(1, 8'hA5, 1, 4'b0010, 2);
    frame(1, 8'h5A, 3, 4'b0010, 1);
    frame(1, 8'hFF, 1, 4'b0100, 1);
    frame(2, 8'hB2, 1, 4'b0000, 1);

    // format write during WAIT_DONE applies only in the following IDLE cycle
    push(0, 1'b1, 8'h5C);
    wait_start(n);
    chk("cfg_byte", 32'(tx_data), 32'h5C);
    @(posedge clk); #1; cfg_wr = 1'b1; cfg_wdata = 5'b01001;
    @(posedge clk); #1; cfg_wr = 1'b0;
    @(negedge clk);
    chk("cfg_held_wait", 32'(cfg_reg), 32'h03);
    chk("cfg_busy", 32'(busy), 1);
    @(posedge clk); #1; tx_done = 1'b1;
    @(posedge clk); #1; tx_done = 1'b0;
    push(2, 1'b1, 8'h6D);
    @(negedge clk);
    chk("cfg_apply_no_grant", 32'(req_ready), 0);
    chk("cfg_held_apply", 32'(cfg_reg), 32'h03);
    @(negedge clk);
    chk("cfg_applied", 32'(cfg_reg), 32'h09);
    chk("cfg_next_ready", 32'(req_ready), 32'h4);
    frame(2, 8'h6D, 2, 4'b0000, 1);

    // serializer hang: watchdog fires 100 cycles after LAUNCH
    push(1, 1'b1, 8'h81); push(3, 1'b1, 8'h83);
    wait_start(n);
    chk("wd_grant", 32'(grant_id), 3);
    n = 0;
    do begin @(negedge clk); n++; end while (!err_timeout && n < 150);
    chk("wd_cycles", n, 100);
    @(posedge clk); #1; tx_done = 1'b1;   // late tx_done, lands in IDLE
    @(negedge clk);
    chk("wd_one_pulse", 32'(err_timeout), 0);
    chk("wd_next_ready", 32'(req_ready), 32'h2);
    @(posedge clk); #1; tx_done = 1'b0;
    frame(1, 8'h81, 2, 4'b0000, 1);

    // locked requester goes quiet: lock released by watchdog
    push(3, 1'b0, 8'h93);
    frame(3, 8'h93, 1, 4'b0000, 2);
    push(0, 1'b1, 8'hA0);
    n = 1;
    @(negedge clk);
    chk("lock_excludes_other", 32'(req_ready), 0);
    while (!err_timeout && n < 150) begin @(negedge clk); n++; end
    chk("hold_wd_cycles", n, 99);
    @(negedge clk);
    chk("hold_wd_release", 32'(req_ready), 32'h1);
    frame(0, 8'hA0, 1, 4'b0000, 1);

    // reset during WAIT_DONE
    push(2, 1'b1, 8'hC2);
    wait_start(n);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_cfg", 32'(cfg_reg), 32'h03);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_start", 32'(tx_start), 0);
    chk("mid_rst_data", 32'(tx_data), 0);
    chk("mid_rst_grant", 32'(grant_id), 0);

    // single requester, back-to-back packets
    push(0, 1'b1, 8'hD0); push(0, 1'b1, 8'hD1);
    frame(0, 8'hD0, 1, 4'b0001, 2);
    frame(0, 8'hD1, 1, 4'b0000, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
